// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM states, iteration count
// and the divide-by-zero quotient default.
package cpu_alu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS_A = 3'd1,
    NEG_D = 3'd2,
    RUN   = 3'd3,
    FIX_Q = 3'd4,
    FIX_R = 3'd5,
    DONE  = 3'd6
  } div_state_e;

  localparam int unsigned DIV_ITER         = 32;
  localparam logic [31:0] DBZ_QUOTIENT_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/alu_div_seq_if.sv
// Request/result bundle between the issue logic (master) and the divider (slave).
interface alu_div_seq_if;

  logic        Start;
  logic        IsSigned;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivByZero;

  modport master (
    output Start, IsSigned, A, B,
    input  Busy, Done, Quotient, Remainder, DivByZero
  );

  modport slave (
    input  Start, IsSigned, A, B,
    output Busy, Done, Quotient, Remainder, DivByZero
  );

endinterface

// File: rtl/alu_div_seq_add.sv
// Fixed 32-bit adder with carry out; the divider's only arithmetic resource.
module alu_add (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Sum,
  output logic        cOut
);

  assign {cOut, Sum} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock, all
// negations and trial subtractions time-shared on a single alu_add.
module alu_div_seq
  import cpu_alu_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] DBZ_QUOTIENT = DBZ_QUOTIENT_DEF
) (
  input  logic         clock,
  input  logic         clear_n,
  alu_div_seq_if.slave bus
);

  if (WIDTH != 32) begin : g_width_check
    $error("alu_div_seq: WIDTH must be 32, alu_add is fixed width");
  end

  localparam logic [4:0] CNT_INIT = 5'(DIV_ITER - 1);

  div_state_e  state_q, state_d;
  logic [31:0] a_q, b_q, dvd_q, r_q, q_q, negd_q, quo_q, rem_q;
  logic        sgn_q, dbz_q;
  logic [4:0]  cnt_q;

  logic [31:0] add_a, add_b, add_sum;
  logic        add_cout;
  logic [32:0] r33;
  logic        sub_ok, accept, b_zero, busy, done;
  logic        neg_a_sel, neg_b_sel, neg_q_sel;

  alu_add u_add (
    .A    (add_a),
    .B    (add_b),
    .Sum  (add_sum),
    .cOut (add_cout)
  );

  assign accept    = (state_q == IDLE) && bus.Start;
  assign b_zero    = (bus.B == '0);
  assign r33       = {r_q, dvd_q[31]};
  // R33[32] covers divisors >= 2^31 whose trial difference overflows 32 bits.
  assign sub_ok    = r33[32] | add_cout;
  assign neg_a_sel = sgn_q & a_q[31];
  assign neg_b_sel = sgn_q & b_q[31];
  assign neg_q_sel = sgn_q & (a_q[31] ^ b_q[31]);

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_q)
      ABS_A: begin add_a = ~a_q;       add_b = 32'd1;  end
      NEG_D: begin add_a = ~b_q;       add_b = 32'd1;  end
      RUN:   begin add_a = r33[31:0];  add_b = negd_q; end
      FIX_Q: begin add_a = ~q_q;       add_b = 32'd1;  end
      FIX_R: begin add_a = ~r_q;       add_b = 32'd1;  end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    case (state_q)
      IDLE:    if (bus.Start) state_d = b_zero ? DONE : ABS_A;
      ABS_A:   state_d = NEG_D;
      NEG_D:   state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FIX_Q;
      FIX_Q:   state_d = FIX_R;
      FIX_R:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      dvd_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      negd_q <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= bus.A;
        b_q   <= bus.B;
        sgn_q <= bus.IsSigned;
        dbz_q <= b_zero;
        if (b_zero) begin
          quo_q <= DBZ_QUOTIENT;
          rem_q <= bus.A;
        end
      end
      case (state_q)
        ABS_A: begin
          dvd_q <= neg_a_sel ? add_sum : a_q;
          r_q   <= '0;
          q_q   <= '0;
          cnt_q <= CNT_INIT;
        end
        NEG_D: negd_q <= neg_b_sel ? b_q : add_sum;
        RUN: begin
          r_q   <= sub_ok ? add_sum : r33[31:0];
          q_q   <= {q_q[30:0], sub_ok};
          dvd_q <= {dvd_q[30:0], 1'b0};
          cnt_q <= cnt_q - 5'd1;
        end
        FIX_Q: if (neg_q_sel) q_q <= add_sum;
        // Remainder fix-up result goes straight to the output register.
        FIX_R: begin
          quo_q <= q_q;
          rem_q <= neg_a_sel ? add_sum : r_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.Quotient  = quo_q;
  assign bus.Remainder = rem_q;
  assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq: latency, signed/unsigned results, boundaries,
// divide-by-zero, Start-while-busy and asynchronous clear.
module tb_alu_div_seq;

  logic        clock;
  logic        clear_n;
  int unsigned checks;
  int unsigned failures;
  int unsigned cyc;

  alu_div_seq_if bus ();

  alu_div_seq #(
    .WIDTH        (32),
    .DBZ_QUOTIENT (32'hFFFF_FFFF)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.A        = a;
    bus.B        = b;
    bus.IsSigned = s;
    bus.Start    = 1'b1;
    @(posedge clock);
    #1;
    bus.Start = 1'b0;
    cyc = 1;
  endtask

  task automatic finish_op(input string tag, input int unsigned ecyc,
                           input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    int unsigned done_cyc;
    logic        busy_ok;
    done_cyc = 0;
    busy_ok  = 1'b1;
    while (done_cyc == 0 && cyc <= 60) begin
      if (bus.Done === 1'b1) done_cyc = cyc;
      else begin
        if (bus.Busy !== 1'b1) busy_ok = 1'b0;
        step();
      end
    end
    chk({tag, "_done_cycle"}, done_cyc, ecyc);
    chk({tag, "_busy_before_done"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_quotient"}, bus.Quotient, eq);
    chk({tag, "_remainder"}, bus.Remainder, er);
    chk({tag, "_dbz"}, {31'b0, bus.DivByZero}, {31'b0, edbz});
    step();
    chk({tag, "_done_pulse_end"}, {31'b0, bus.Done}, 32'd0);
    chk({tag, "_idle_after"}, {31'b0, bus.Busy}, 32'd0);
    chk({tag, "_quotient_held"}, bus.Quotient, eq);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    clear_n      = 1'b0;
    bus.Start    = 1'b0;
    bus.IsSigned = 1'b0;
    bus.A        = '0;
    bus.B        = '0;

    #12;
    chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
    chk("rst_done", {31'b0, bus.Done}, 32'd0);
    chk("rst_quotient", bus.Quotient, 32'd0);
    chk("rst_remainder", bus.Remainder, 32'd0);
    chk("rst_dbz", {31'b0, bus.DivByZero}, 32'd0);
    clear_n = 1'b1;
    @(posedge clock);
    #1;

    start_op(32'd100, 32'd7, 1'b0);
    finish_op("u100_7", 37, 32'd14, 32'd2, 1'b0);

    start_op(32'hFFFF_FF9C, 32'd7, 1'b1);
    finish_op("s_m100_7", 37, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    start_op(32'd100, 32'hFFFF_FFF9, 1'b1);
    finish_op("s_100_m7", 37, 32'hFFFF_FFF2, 32'd2, 1'b0);

    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    finish_op("s_min_m1", 37, 32'h8000_0000, 32'd0, 1'b0);

    start_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    finish_op("u_max_2p31", 37, 32'd1, 32'h7FFF_FFFF, 1'b0);

    start_op(32'h0000_1234, 32'd0, 1'b0);
    finish_op("u_dbz", 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);

    start_op(32'h0000_1234, 32'd0, 1'b1);
    finish_op("s_dbz", 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);

    // Second Start in cycle 10 must not disturb the running 100/7.
    start_op(32'd100, 32'd7, 1'b0);
    while (cyc < 10) step();
    bus.A        = 32'd50;
    bus.B        = 32'd3;
    bus.IsSigned = 1'b1;
    bus.Start    = 1'b1;
    step();
    bus.Start = 1'b0;
    finish_op("start_ignored", 37, 32'd14, 32'd2, 1'b0);

    start_op(32'hFFFF_FF9C, 32'd7, 1'b1);
    while (cyc < 20) step();
    clear_n = 1'b0;
    #1;
    chk("clr_busy", {31'b0, bus.Busy}, 32'd0);
    chk("clr_done", {31'b0, bus.Done}, 32'd0);
    chk("clr_quotient", bus.Quotient, 32'd0);
    chk("clr_remainder", bus.Remainder, 32'd0);
    chk("clr_dbz", {31'b0, bus.DivByZero}, 32'd0);
    #2;
    clear_n = 1'b1;
    @(posedge clock);
    #1;
    start_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    finish_op("after_clear", 37, 32'hFFFF_FFFD, 32'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
